// File: rtl/raster_scan_gen.sv
// -----------------------------------------------------------------------------
// raster_scan_gen
//
// Triangle sample generator. Accepts one fixed-point triangle (three x/y
// vertices plus an opaque attribute word) per handshake, derives the
// screen-clipped pixel bounding box in a one-cycle SETUP state, then streams
// pixel-centre sample points under valid/ready backpressure at up to one
// sample per clock. Row changes happen in the same cycle as an advance, so
// there is no bubble at row boundaries. Optional serpentine order reverses the
// x direction on odd rows of the box.
//
// Ports:
//   clk_in           clock, rising edge
//   rst_n_in         asynchronous active-low reset
//   tri_valid_in     triangle beat valid
//   tri_ready_out    high while idle (ready to accept a triangle)
//   tri_in           {v2y,v2x,v1y,v1x,v0y,v0x}, unsigned UQ(INT_BITS.FRAC_BITS)
//   attr_in          attribute captured together with the triangle
//   sample_valid_out sample beat valid
//   sample_ready_in  downstream accepts the sample
//   sample_out       {y,x} sample coordinate, fraction always 0.5
//   sample_id_out    id of the triangle owning the sample
//   sample_attr_out  captured attribute
//   sample_last_out  final sample of the triangle
//   busy_out         high while a triangle is being processed
//
// FRAC_BITS must be at least 2.
// -----------------------------------------------------------------------------
module raster_scan_gen #(
    parameter int SCREEN_W   = 320,
    parameter int SCREEN_H   = 240,
    parameter int INT_BITS   = 9,
    parameter int FRAC_BITS  = 8,
    parameter int ATTR_W     = 12,
    parameter int ID_W       = 16,
    parameter int SERPENTINE = 0
) (
    input  logic                                  clk_in,
    input  logic                                  rst_n_in,
    input  logic                                  tri_valid_in,
    output logic                                  tri_ready_out,
    input  logic [6*(INT_BITS+FRAC_BITS)-1:0]     tri_in,
    input  logic [ATTR_W-1:0]                     attr_in,
    output logic                                  sample_valid_out,
    input  logic                                  sample_ready_in,
    output logic [2*(INT_BITS+FRAC_BITS)-1:0]     sample_out,
    output logic [ID_W-1:0]                       sample_id_out,
    output logic [ATTR_W-1:0]                     sample_attr_out,
    output logic                                  sample_last_out,
    output logic                                  busy_out
);

    localparam int CW = INT_BITS + FRAC_BITS;
    localparam logic [INT_BITS-1:0]  X_LIM = INT_BITS'(SCREEN_W - 1);
    localparam logic [INT_BITS-1:0]  Y_LIM = INT_BITS'(SCREEN_H - 1);
    localparam logic [FRAC_BITS-1:0] HALF  = {1'b1, {(FRAC_BITS-1){1'b0}}};
    localparam bit                   SERP  = (SERPENTINE != 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SCAN  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [ID_W-1:0]        idCnt_q, idCnt_d;
    logic [ID_W-1:0]        id_q, id_d;
    logic [6*CW-1:0]        tri_q, tri_d;
    logic [ATTR_W-1:0]      attr_q, attr_d;
    logic [INT_BITS-1:0]    loX_q, loX_d, hiX_q, hiX_d;
    logic [INT_BITS-1:0]    loY_q, loY_d, hiY_q, hiY_d;
    logic [INT_BITS-1:0]    xPix_q, xPix_d, yPix_q, yPix_d;
    logic                   odd_q, odd_d;
    logic [2*CW-1:0]        sample_q, sample_d;
    logic                   last_q, last_d;
    logic                   valid_q, valid_d;

    // Box along one axis, packed as {empty, hi, lo}.
    // The floor of the minimum equals the minimum of the floors, so lo only
    // needs integer parts. hi is the largest p with p+0.5 <= max, i.e.
    // floor(max) when the fraction is at least one half, else floor(max)-1;
    // when that would go negative the axis is empty. A lo beyond the screen
    // edge is also empty rather than being pulled back onto the last column.
    function automatic logic [2*INT_BITS:0] axisBox(
        input logic [CW-1:0]       a,
        input logic [CW-1:0]       b,
        input logic [CW-1:0]       c,
        input logic [INT_BITS-1:0] lim
    );
        logic [INT_BITS-1:0] lo;
        logic [INT_BITS-1:0] hi;
        logic [INT_BITS-1:0] maxInt;
        logic [CW-1:0]       mx;
        logic                below;
        logic                empty;
        lo = a[CW-1:FRAC_BITS];
        if (b[CW-1:FRAC_BITS] < lo) lo = b[CW-1:FRAC_BITS];
        if (c[CW-1:FRAC_BITS] < lo) lo = c[CW-1:FRAC_BITS];
        mx = a;
        if (b > mx) mx = b;
        if (c > mx) mx = c;
        maxInt = mx[CW-1:FRAC_BITS];
        below  = (mx[FRAC_BITS-1:0] < HALF);
        empty  = (lo > lim) || (below && (maxInt == '0));
        hi     = maxInt - INT_BITS'(below);
        if (hi > lim) hi = lim;
        if (lo > lim) lo = lim;
        if (hi < lo) empty = 1'b1;
        return {empty, hi, lo};
    endfunction

    // Pixel index to pixel-centre coordinate (fraction = 0.5).
    function automatic logic [CW-1:0] centre(input logic [INT_BITS-1:0] pix);
        return {pix, 1'b1, {(FRAC_BITS-1){1'b0}}};
    endfunction

    logic [2*INT_BITS:0]   boxX, boxY;
    logic [INT_BITS-1:0]   setLoX, setHiX, setLoY, setHiY;
    logic                  setEmpty;

    // Bounding box of the registered triangle; only consumed in SETUP.
    assign boxX = axisBox(tri_q[0*CW +: CW], tri_q[2*CW +: CW], tri_q[4*CW +: CW], X_LIM);
    assign boxY = axisBox(tri_q[1*CW +: CW], tri_q[3*CW +: CW], tri_q[5*CW +: CW], Y_LIM);

    assign setLoX   = boxX[INT_BITS-1:0];
    assign setHiX   = boxX[2*INT_BITS-1:INT_BITS];
    assign setLoY   = boxY[INT_BITS-1:0];
    assign setHiY   = boxY[2*INT_BITS-1:INT_BITS];
    assign setEmpty = boxX[2*INT_BITS] | boxY[2*INT_BITS];

    logic [INT_BITS-1:0]   rowEnd, nextX, nextY, nextRowEnd;
    logic                  nextOdd;

    // Walk to the next pixel of the box. The row end depends on direction:
    // reversed rows finish at lo, forward rows at hi. Stepping past a row end
    // moves to the next row and flips direction in the same cycle, which keeps
    // the stream gap-free across rows.
    always_comb begin
        rowEnd     = (SERP && odd_q) ? loX_q : hiX_q;
        nextX      = xPix_q;
        nextY      = yPix_q;
        nextOdd    = odd_q;
        if (xPix_q == rowEnd) begin
            nextY   = yPix_q + 1'b1;
            nextOdd = ~odd_q;
            nextX   = (SERP && ~odd_q) ? hiX_q : loX_q;
        end else if (SERP && odd_q) begin
            nextX = xPix_q - 1'b1;
        end else begin
            nextX = xPix_q + 1'b1;
        end
        nextRowEnd = (SERP && nextOdd) ? loX_q : hiX_q;
    end

    // Next-state and datapath update for the IDLE -> SETUP -> SCAN sequence.
    // Every register holds by default, which also keeps all sample outputs
    // stable while downstream stalls.
    always_comb begin
        state_d  = state_q;
        idCnt_d  = idCnt_q;
        id_d     = id_q;
        tri_d    = tri_q;
        attr_d   = attr_q;
        loX_d    = loX_q;
        hiX_d    = hiX_q;
        loY_d    = loY_q;
        hiY_d    = hiY_q;
        xPix_d   = xPix_q;
        yPix_d   = yPix_q;
        odd_d    = odd_q;
        sample_d = sample_q;
        last_d   = last_q;
        valid_d  = valid_q;

        case (state_q)
            IDLE: begin
                if (tri_valid_in) begin
                    tri_d   = tri_in;
                    attr_d  = attr_in;
                    id_d    = idCnt_q;
                    idCnt_d = idCnt_q + 1'b1;
                    state_d = SETUP;
                end
            end

            SETUP: begin
                // An empty box still consumed its id at accept time.
                if (setEmpty) begin
                    state_d = IDLE;
                end else begin
                    loX_d    = setLoX;
                    hiX_d    = setHiX;
                    loY_d    = setLoY;
                    hiY_d    = setHiY;
                    xPix_d   = setLoX;
                    yPix_d   = setLoY;
                    odd_d    = 1'b0;
                    sample_d = {centre(setLoY), centre(setLoX)};
                    last_d   = (setLoY == setHiY) && (setLoX == setHiX);
                    valid_d  = 1'b1;
                    state_d  = SCAN;
                end
            end

            SCAN: begin
                if (valid_q && sample_ready_in) begin
                    if (last_q) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        xPix_d   = nextX;
                        yPix_d   = nextY;
                        odd_d    = nextOdd;
                        sample_d = {centre(nextY), centre(nextX)};
                        last_d   = (nextY == hiY_q) && (nextX == nextRowEnd);
                    end
                end
            end

            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                last_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers. Reset discards any triangle in flight
    // and drops sample_valid_out immediately.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q  <= IDLE;
            idCnt_q  <= '0;
            id_q     <= '0;
            tri_q    <= '0;
            attr_q   <= '0;
            loX_q    <= '0;
            hiX_q    <= '0;
            loY_q    <= '0;
            hiY_q    <= '0;
            xPix_q   <= '0;
            yPix_q   <= '0;
            odd_q    <= 1'b0;
            sample_q <= '0;
            last_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idCnt_q  <= idCnt_d;
            id_q     <= id_d;
            tri_q    <= tri_d;
            attr_q   <= attr_d;
            loX_q    <= loX_d;
            hiX_q    <= hiX_d;
            loY_q    <= loY_d;
            hiY_q    <= hiY_d;
            xPix_q   <= xPix_d;
            yPix_q   <= yPix_d;
            odd_q    <= odd_d;
            sample_q <= sample_d;
            last_q   <= last_d;
            valid_q  <= valid_d;
        end
    end

    assign tri_ready_out    = (state_q == IDLE);
    assign busy_out         = (state_q != IDLE);
    assign sample_valid_out = valid_q;
    assign sample_out       = sample_q;
    assign sample_id_out    = id_q;
    assign sample_attr_out  = attr_q;
    assign sample_last_out  = last_q;

endmodule

// File: tb/tb_raster_scan_gen.sv
// -----------------------------------------------------------------------------
// tb_raster_scan_gen
//
// Two instances share clock and reset: dutA uses default parameters,
// dutB uses SERPENTINE=1 and ID_W=2. Stimulus pushes the hand-derived sample
// list of each triangle into a per-instance queue before issuing it; the
// monitor pops and compares on every accepted sample and also checks that a
// stalled sample stays put.
// -----------------------------------------------------------------------------
module tb_raster_scan_gen;

    localparam int CW = 17;

    typedef struct {
        logic [2*CW-1:0] s;
        logic [15:0]     id;
        logic [11:0]     attr;
        logic            last;
    } exp_t;

    logic clk;
    logic rst_n;

    logic            triValidA, triReadyA, validA, readyA, lastA, busyA;
    logic [6*CW-1:0] triA;
    logic [11:0]     attrInA, attrA;
    logic [2*CW-1:0] sampleA;
    logic [15:0]     idA;

    logic            triValidB, triReadyB, validB, readyB, lastB, busyB;
    logic [6*CW-1:0] triB;
    logic [11:0]     attrInB, attrB;
    logic [2*CW-1:0] sampleB;
    logic [1:0]      idB;

    exp_t            qA[$];
    exp_t            qB[$];
    int              compared   = 0;
    int              mismatched = 0;
    logic            holdF[2];
    logic [2*CW-1:0] heldS[2];

    raster_scan_gen dutA (
        .clk_in           (clk),
        .rst_n_in         (rst_n),
        .tri_valid_in     (triValidA),
        .tri_ready_out    (triReadyA),
        .tri_in           (triA),
        .attr_in          (attrInA),
        .sample_valid_out (validA),
        .sample_ready_in  (readyA),
        .sample_out       (sampleA),
        .sample_id_out    (idA),
        .sample_attr_out  (attrA),
        .sample_last_out  (lastA),
        .busy_out         (busyA)
    );

    raster_scan_gen #(.SERPENTINE(1), .ID_W(2)) dutB (
        .clk_in           (clk),
        .rst_n_in         (rst_n),
        .tri_valid_in     (triValidB),
        .tri_ready_out    (triReadyB),
        .tri_in           (triB),
        .attr_in          (attrInB),
        .sample_valid_out (validB),
        .sample_ready_in  (readyB),
        .sample_out       (sampleB),
        .sample_id_out    (idB),
        .sample_attr_out  (attrB),
        .sample_last_out  (lastB),
        .busy_out         (busyB)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something wedges beyond every bounded wait.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [CW-1:0] centre(input int pix);
        return CW'((pix << 8) | 128);
    endfunction

    function automatic logic [6*CW-1:0] mkTri(input int v0x, input int v0y, input int v1x,
                                              input int v1y, input int v2x, input int v2y);
        return {CW'(v2y), CW'(v2x), CW'(v1y), CW'(v1x), CW'(v0y), CW'(v0x)};
    endfunction

    // Expected sample order for a box given in pixel indices.
    task automatic pushBox(input int which, input int lox, input int hix, input int loy,
                           input int hiy, input int id, input logic [11:0] attr, input bit serp);
        exp_t e;
        int   x;
        for (int y = loy; y <= hiy; y++) begin
            for (int k = 0; k <= hix - lox; k++) begin
                x = (serp && ((y - loy) % 2 == 1)) ? hix - k : lox + k;
                e.s    = {centre(y), centre(x)};
                e.id   = 16'(id);
                e.attr = attr;
                e.last = (y == hiy) && (k == hix - lox);
                if (which == 0) qA.push_back(e);
                else            qB.push_back(e);
            end
        end
    endtask

    // Offer a triangle; returns 1 ns after the accepting clock edge.
    task automatic applyStimulus(input int which, input logic [6*CW-1:0] t, input logic [11:0] a);
        int n = 0;
        while (((which == 0) ? triReadyA : triReadyB) !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL tri_ready wait: got 0, expected 1 within 200 cycles");
        end
        if (which == 0) begin
            triA = t; attrInA = a; triValidA = 1'b1;
        end else begin
            triB = t; attrInB = a; triValidB = 1'b1;
        end
        @(posedge clk); #1;
        triValidA = 1'b0;
        triValidB = 1'b0;
    endtask

    task automatic waitDrain(input int which, input int budget);
        int n = 0;
        while (n < budget && ((which == 0) ? (qA.size() != 0 || busyA) : (qB.size() != 0 || busyB))) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput((which == 0) ? "A drain pending" : "B drain pending",
                    (which == 0) ? 64'(qA.size()) : 64'(qB.size()), 0);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        qA.delete();
        qB.delete();
    endtask

    task automatic monitorPort(input int which, input logic v, input logic r,
                               input logic [2*CW-1:0] s, input logic [15:0] id,
                               input logic [11:0] a, input logic l);
        exp_t  e;
        string tag;
        tag = (which == 0) ? "A" : "B";
        if (v) begin
            if (holdF[which]) checkOutput({tag, " held sample"}, s, heldS[which]);
            if (r) begin
                holdF[which] = 1'b0;
                if ((which == 0) ? (qA.size() == 0) : (qB.size() == 0)) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL %s unexpected sample: got 0x%0h, expected none", tag, s);
                end else begin
                    if (which == 0) e = qA.pop_front();
                    else            e = qB.pop_front();
                    checkOutput({tag, " sample"}, s, e.s);
                    checkOutput({tag, " id"},     id, e.id);
                    checkOutput({tag, " attr"},   a, e.attr);
                    checkOutput({tag, " last"},   l, e.last);
                end
            end else begin
                holdF[which] = 1'b1;
                heldS[which] = s;
            end
        end else begin
            if (holdF[which]) checkOutput({tag, " held valid"}, v, 1);
            holdF[which] = 1'b0;
        end
    endtask

    // Scoreboard monitor on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            holdF[0] = 1'b0;
            holdF[1] = 1'b0;
        end else begin
            monitorPort(0, validA, readyA, sampleA, idA, attrA, lastA);
            monitorPort(1, validB, readyB, sampleB, {14'b0, idB}, attrB, lastB);
        end
    end

    initial begin
        logic [6*CW-1:0] triBasic, triClip, triEmpty, triSerp, triOne;
        // 3.2 = 0x333, 2.7 = 0x2B3, 10.9 = 0xAE6, 5.1 = 0x51A, 5.4 = 0x566, 4.6 = 0x49A
        triBasic = mkTri(16'h100, 16'h100, 16'h333, 16'h100, 16'h100, 16'h2B3);
        triClip  = mkTri(330*256, 10*256, 300*256, 10*256, 300*256, 16'hAE6);
        triEmpty = mkTri(16'h51A, 16'h100, 16'h566, 16'h100, 16'h51A, 16'h300);
        triSerp  = mkTri(0, 0, 3*256, 0, 0, 2*256);
        triOne   = mkTri(16'h400, 16'h400, 16'h49A, 16'h400, 16'h400, 16'h49A);

        holdF[0] = 1'b0; holdF[1] = 1'b0;
        rst_n = 1'b0;
        triValidA = 1'b0; triValidB = 1'b0;
        triA = '0; triB = '0; attrInA = '0; attrInB = '0;
        readyA = 1'b1; readyB = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset tri_ready", triReadyA, 1);
        checkOutput("reset sample_valid", validA, 0);
        checkOutput("reset busy", busyA, 0);
        checkOutput("reset sample", sampleA, 0);
        checkOutput("reset id", idA, 0);
        checkOutput("reset attr", attrA, 0);
        checkOutput("reset last", lastA, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic 2x2 box, first sample two edges after accept.
        $display("[TB] basic");
        pushBox(0, 1, 2, 1, 2, 0, 12'hABC, 0);
        applyStimulus(0, triBasic, 12'hABC);
        checkOutput("basic setup valid", validA, 0);
        checkOutput("basic busy", busyA, 1);
        checkOutput("basic tri_ready", triReadyA, 0);
        @(posedge clk); #1;
        checkOutput("basic first valid", validA, 1);
        waitDrain(0, 50);

        // Empty box consumes id 0; the next triangle gets id 1.
        $display("[TB] empty");
        doReset();
        applyStimulus(0, triEmpty, 12'h111);
        checkOutput("empty tri_ready low", triReadyA, 0);
        @(posedge clk); #1;
        checkOutput("empty tri_ready back", triReadyA, 1);
        checkOutput("empty no valid", validA, 0);
        pushBox(0, 1, 2, 1, 2, 1, 12'h222, 0);
        applyStimulus(0, triBasic, 12'h222);
        waitDrain(0, 50);

        // Stall sample 2 for three clocks.
        $display("[TB] backpressure");
        pushBox(0, 1, 2, 1, 2, 2, 12'h333, 0);
        applyStimulus(0, triBasic, 12'h333);
        @(posedge clk); #1;
        @(posedge clk); #1;
        readyA = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        readyA = 1'b1;
        waitDrain(0, 50);

        // Right-edge clip: x 300..319 on a single row y=10.
        $display("[TB] clip");
        pushBox(0, 300, 319, 10, 10, 3, 12'h444, 0);
        applyStimulus(0, triClip, 12'h444);
        waitDrain(0, 100);

        // Reset in the middle of a scan.
        $display("[TB] reset mid-scan");
        pushBox(0, 1, 2, 1, 2, 4, 12'h555, 0);
        applyStimulus(0, triBasic, 12'h555);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checkOutput("mid reset valid", validA, 0);
        checkOutput("mid reset busy", busyA, 0);
        qA.delete();
        qB.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("post reset valid", validA, 0);
        pushBox(0, 1, 2, 1, 2, 0, 12'h666, 0);
        applyStimulus(0, triBasic, 12'h666);
        waitDrain(0, 50);

        // Serpentine 3x2 box, then id wrap on the 2-bit counter.
        $display("[TB] serpentine / wrap");
        pushBox(1, 0, 2, 0, 1, 0, 12'h777, 1);
        applyStimulus(1, triSerp, 12'h777);
        waitDrain(1, 50);
        for (int i = 1; i <= 4; i++) begin
            pushBox(1, 4, 4, 4, 4, i % 4, 12'(i), 1);
            applyStimulus(1, triOne, 12'(i));
            waitDrain(1, 50);
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
